// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle instruction sequencer for a small single-issue core.
// Walks each instruction through FETCH -> DECODE -> EXEC -> (MEM | WB | BRCHK) and
// back to FETCH. It keeps sequencing until it meets a halt instruction or reset.
//
// Ports
//   clk, reset                 clock (rising edge) and asynchronous active-high reset
//   start                      leaves IDLE; ignored in every other state
//   instr[15:0]                instruction word (opcode = [15:13], funct = [0])
//   imem_req / imem_ready      fetch request held until the word is valid
//   dmem_read / dmem_write     data strobes held until dmem_ready
//   zero                       ALU zero flag, sampled in BRCHK
//   opcode, ALUsrc, ALUcontrol ALU controls, loaded in DECODE and held until the next DECODE
//   ex_stage                   toggles once on every entry to EXEC
//   reg_write                  one-cycle pulse in WB
//   pc_inc, pc_load            one-cycle pulses in the retiring cycle of an instruction
//   busy, halted               state is not IDLE/HALT; state is HALT
//   instr_count[7:0]           retired-instruction counter (wraps)
//
// pc_inc and pc_load depend on dmem_ready and zero in the retiring cycle, so they are
// decoded from the current state and inputs. Every other output is a register loaded
// from the next state.
//
// Build option: define BRANCH_EN to decode opcode 011 as beq, which adds the BRCHK
// state. Without it, 011 is a NOP.
module stage_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] instr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        zero,
    output logic [2:0]  opcode,
    output logic        ALUcontrol,
    output logic        ALUsrc,
    output logic        ex_stage,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic        reg_write,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        busy,
    output logic        halted,
    output logic [7:0]  instr_count
);

    localparam int unsigned OP_W = 3;
    localparam int unsigned CNT_W = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
`ifdef BRANCH_EN
    localparam logic [2:0] S_BRCHK  = 3'd7;
`endif

    localparam logic [OP_W-1:0] OP_R    = 3'b000;
    localparam logic [OP_W-1:0] OP_LW   = 3'b001;
    localparam logic [OP_W-1:0] OP_SW   = 3'b010;
    localparam logic [OP_W-1:0] OP_ADDI = 3'b100;
    localparam logic [OP_W-1:0] OP_HALT = 3'b111;
`ifdef BRANCH_EN
    localparam logic [OP_W-1:0] OP_BEQ  = 3'b011;
`endif

    logic [2:0]       state_q, state_d;
    logic [3:0]       fetch_q, fetch_d;     // latched {opcode, funct}
    logic [OP_W-1:0]  opcode_d;
    logic             alu_src_d, alu_ctl_d;
    logic [CNT_W-1:0] count_d;

    // Only the opcode field and funct bit are needed; the remaining bits feed the datapath elsewhere.
    logic unused_inputs;
`ifdef BRANCH_EN
    assign unused_inputs = ^instr[12:1];
`else
    assign unused_inputs = ^{instr[12:1], zero};
`endif

    // State and latched instruction fields
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            fetch_q <= '0;
        end else begin
            state_q <= state_d;
            fetch_q <= fetch_d;
        end
    end

    // Next-state, decode and retire-pulse logic
    always_comb begin
        state_d   = state_q;
        fetch_d   = fetch_q;
        opcode_d  = opcode;
        alu_src_d = ALUsrc;
        alu_ctl_d = ALUcontrol;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    fetch_d = {instr[15:13], instr[0]};
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                opcode_d  = fetch_q[3:1];
                alu_src_d = 1'b0;
                alu_ctl_d = 1'b0;
                case (fetch_q[3:1])
                    OP_R:                 alu_ctl_d = fetch_q[0];
                    OP_LW, OP_SW, OP_ADDI: alu_src_d = 1'b1;
`ifdef BRANCH_EN
                    OP_BEQ:               alu_ctl_d = 1'b1;
`endif
                    default: ;
                endcase
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_R, OP_ADDI: state_d = S_WB;
                    OP_LW, OP_SW:  state_d = S_MEM;
                    OP_HALT:       state_d = S_HALT;
`ifdef BRANCH_EN
                    OP_BEQ:        state_d = S_BRCHK;
`endif
                    default: begin
                        // NOP retires straight out of EXEC
                        pc_inc  = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (opcode == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        pc_inc  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                pc_inc  = 1'b1;
                state_d = S_FETCH;
            end
`ifdef BRANCH_EN
            S_BRCHK: begin
                pc_load = zero;
                pc_inc  = ~zero;
                state_d = S_FETCH;
            end
`endif
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        count_d = instr_count + CNT_W'(pc_inc | pc_load);
    end

    // Registered outputs, loaded from the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode      <= '0;
            ALUsrc      <= 1'b0;
            ALUcontrol  <= 1'b0;
            ex_stage    <= 1'b0;
            imem_req    <= 1'b0;
            dmem_read   <= 1'b0;
            dmem_write  <= 1'b0;
            reg_write   <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            opcode      <= opcode_d;
            ALUsrc      <= alu_src_d;
            ALUcontrol  <= alu_ctl_d;
            ex_stage    <= ex_stage ^ ((state_d == S_EXEC) && (state_q != S_EXEC));
            imem_req    <= (state_d == S_FETCH);
            dmem_read   <= (state_d == S_MEM) && (opcode_d == OP_LW);
            dmem_write  <= (state_d == S_MEM) && (opcode_d == OP_SW);
            reg_write   <= (state_d == S_WB);
            busy        <= (state_d != S_IDLE) && (state_d != S_HALT);
            halted      <= (state_d == S_HALT);
            instr_count <= count_d;
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer. Each instruction's cycle-by-cycle expectations
// are built from its class and the ready/zero delays applied. A negedge process
// compares every output against them.
module tb_stage_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        zero = 1'b0;
    logic        imem_req, ALUcontrol, ALUsrc, ex_stage, dmem_read, dmem_write;
    logic        reg_write, pc_inc, pc_load, busy, halted;
    logic [2:0]  opcode;
    logic [7:0]  instr_count;

    int checks = 0;
    int errors = 0;
    int inc_seen = 0;
    bit chk_en = 1'b0;
    bit g_start = 1'b0;

    // expected per-cycle strobes
    bit e_im, e_rd, e_wr, e_rw, e_inc, e_ld, e_busy, e_halt;
    // model state
    logic       m_ex;
    logic [7:0] m_count;
    logic [2:0] m_op;
    logic       m_src, m_ctl;

    localparam int C_ALU = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_NOP = 4, C_HALT = 5;

    stage_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .instr(instr),
        .imem_req(imem_req), .imem_ready(imem_ready), .dmem_ready(dmem_ready), .zero(zero),
        .opcode(opcode), .ALUcontrol(ALUcontrol), .ALUsrc(ALUsrc), .ex_stage(ex_stage),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .reg_write(reg_write),
        .pc_inc(pc_inc), .pc_load(pc_load), .busy(busy), .halted(halted),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_req",    32'(imem_req),    32'(e_im));
            chk("dmem_read",   32'(dmem_read),   32'(e_rd));
            chk("dmem_write",  32'(dmem_write),  32'(e_wr));
            chk("reg_write",   32'(reg_write),   32'(e_rw));
            chk("pc_inc",      32'(pc_inc),      32'(e_inc));
            chk("pc_load",     32'(pc_load),     32'(e_ld));
            chk("busy",        32'(busy),        32'(e_busy));
            chk("halted",      32'(halted),      32'(e_halt));
            chk("ex_stage",    32'(ex_stage),    32'(m_ex));
            chk("instr_count", 32'(instr_count), 32'(m_count));
            chk("opcode",      32'(opcode),      32'(m_op));
            chk("ALUsrc",      32'(ALUsrc),      32'(m_src));
            chk("ALUcontrol",  32'(ALUcontrol),  32'(m_ctl));
            if (pc_inc === 1'b1) inc_seen++;
        end
    end

    // One clock cycle: drive inputs and expectations just after posedge
    task automatic cyc(input bit st, input bit ir, input bit dr, input bit z,
                       input bit x_im, input bit x_rd, input bit x_wr, input bit x_rw,
                       input bit x_inc, input bit x_ld, input bit x_busy, input bit x_halt);
        start = st; imem_ready = ir; dmem_ready = dr; zero = z;
        e_im = x_im; e_rd = x_rd; e_wr = x_wr; e_rw = x_rw;
        e_inc = x_inc; e_ld = x_ld; e_busy = x_busy; e_halt = x_halt;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit st);
        cyc(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        m_ex = 1'b0; m_count = 8'd0; m_op = 3'd0; m_src = 1'b0; m_ctl = 1'b0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
        reset = 1'b1;
        #2;
        chk("rst_busy",   32'(busy),        32'd0);
        chk("rst_halted", 32'(halted),      32'd0);
        chk("rst_count",  32'(instr_count), 32'd0);
        chk("rst_imem",   32'(imem_req),    32'd0);
        chk("rst_ex",     32'(ex_stage),    32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
    endtask

    // Runs one instruction from its first FETCH cycle to its retiring cycle
    task automatic run_instr(input logic [15:0] ins, input int iw, input int dw,
                             input bit z, input bit abort, output int ncyc);
        logic [2:0] op;
        int cls;
        bit src, ctl;
        op = ins[15:13]; src = 1'b0; ctl = 1'b0;
        case (op)
            3'b000: begin cls = C_ALU; ctl = ins[0]; end
            3'b100: begin cls = C_ALU; src = 1'b1; end
            3'b001: begin cls = C_LW;  src = 1'b1; end
            3'b010: begin cls = C_SW;  src = 1'b1; end
            3'b111: cls = C_HALT;
`ifdef BRANCH_EN
            3'b011: begin cls = C_BEQ; ctl = 1'b1; end
`endif
            default: cls = C_NOP;
        endcase
        ncyc = 0;
        // FETCH; a halt word sits on the bus except in the ready cycle, and dmem_ready is high
        for (int k = 0; k <= iw; k++) begin
            instr = (k == iw) ? ins : 16'hE000;
            cyc(g_start, k == iw, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
            ncyc++;
        end
        instr = 16'hE000;
        cyc(g_start, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);   // DECODE
        ncyc++;
        m_op = op; m_src = src; m_ctl = ctl; m_ex = ~m_ex;
        cyc(g_start, 1, 1, 0, 0, 0, 0, 0, cls == C_NOP, 0, 1, 0);   // EXEC
        ncyc++;
        if (cls == C_NOP) m_count++;
        case (cls)
            C_ALU: begin
                cyc(g_start, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0);
                ncyc++; m_count++;
            end
            C_LW: begin
                for (int k = 0; k <= dw; k++) begin
                    cyc(g_start, 1, k == dw, 0, 0, 1, 0, 0, 0, 0, 1, 0);
                    ncyc++;
                end
                cyc(g_start, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0);
                ncyc++; m_count++;
            end
            C_SW: begin
                for (int k = 0; k <= dw; k++) begin
                    if (abort && k == 1) begin
                        chk_en = 1'b0;
                        chk("pre_abort_wr", 32'(dmem_write), 32'd1);
                        start = 1'b0; dmem_ready = 1'b0;
                        reset = 1'b1;
                        #1;
                        chk("abort_wr",   32'(dmem_write), 32'd0);
                        chk("abort_busy", 32'(busy),       32'd0);
                        chk("abort_inc",  32'(pc_inc),     32'd0);
                        model_reset();
                        @(negedge clk);
                        reset = 1'b0;
                        @(posedge clk);
                        #1;
                        chk_en = 1'b1;
                        return;
                    end
                    cyc(g_start, 1, k == dw, 0, 0, 0, 1, 0, k == dw, 0, 1, 0);
                    ncyc++;
                end
                m_count++;
            end
            C_BEQ: begin
                cyc(g_start, 0, 0, z, 0, 0, 0, 0, !z, z, 1, 0);
                ncyc++; m_count++;
            end
            default: ;
        endcase
    endtask

    initial begin
        int n;
        #1;
        do_reset();
        idle(0);
        idle(0);
        idle(1);
        g_start = 1'b1;   // start held high while busy must have no effect

        run_instr(16'h0001, 0, 0, 0, 0, n);
        chk("sub_count",  32'(instr_count), 32'd1);
        chk("sub_ex",     32'(ex_stage),    32'd1);
        chk("sub_cycles", 32'(n),           32'd4);
        chk("sub_ctl",    32'(ALUcontrol),  32'd1);

        run_instr(16'h2000, 0, 3, 0, 0, n);
        chk("lw_cycles", 32'(n), 32'd8);

        run_instr(16'h6000, 0, 0, 1, 0, n);
        run_instr(16'h6000, 0, 0, 0, 0, n);
`ifdef BRANCH_EN
        chk("beq_cycles", 32'(n), 32'd4);
`else
        chk("beq_as_nop_cycles", 32'(n), 32'd3);
`endif

        run_instr(16'h8005, 2, 0, 0, 0, n);
        chk("addi_cycles", 32'(n), 32'd6);
        chk("addi_src",    32'(ALUsrc), 32'd1);
        run_instr(16'h0000, 0, 0, 0, 0, n);
        run_instr(16'h4000, 0, 2, 0, 0, n);
        chk("sw_cycles", 32'(n), 32'd6);
        run_instr(16'hA000, 0, 0, 0, 0, n);
        run_instr(16'hC000, 0, 0, 0, 0, n);
        chk("prog_count", 32'(instr_count), 32'd9);
        g_start = 1'b0;

        // 256 NOPs wrap the counter
        do_reset();
        idle(1);
        inc_seen = 0;
        for (int i = 0; i < 256; i++) run_instr(16'hA000, 0, 0, 0, 0, n);
        chk("wrap_count", 32'(instr_count), 32'd0);
        chk("wrap_inc",   32'(inc_seen),    32'd256);

        // halt is absorbing and does not count
        do_reset();
        idle(1);
        run_instr(16'hA000, 0, 0, 0, 0, n);
        run_instr(16'hE000, 0, 0, 0, 0, n);
        for (int i = 0; i < 4; i++) cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("halt_halted", 32'(halted),      32'd1);
        chk("halt_busy",   32'(busy),        32'd0);
        chk("halt_count",  32'(instr_count), 32'd1);
        do_reset();
        chk("halt_reset", 32'(halted), 32'd0);

        // reset in the middle of a stalled sw
        idle(1);
        inc_seen = 0;
        run_instr(16'h4000, 0, 5, 0, 1, n);
        idle(0);
        idle(0);
        idle(0);
        chk("abort_no_inc",   32'(inc_seen), 32'd0);
        chk("abort_idle_req", 32'(imem_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 The block SHALL have one clock, clk (rising edge), and one reset, reset (asynchronous, active-high).
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- start  in  1  leave IDLE and begin sequencing
- instr  in  16  instruction word; opcode=instr[15:13], funct=instr[0]
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data memory access complete this cycle
- zero  in  1  ALU result == 0, sampled in BRCHK
- opcode  out  3  registered opcode to ALU
- ALUcontrol  out  1  0=add, 1=subtract
- ALUsrc  out  1  0=reg/reg, 1=reg/immediate
- ex_stage  out  1  ALU trigger; toggles once per EXEC entry
- dmem_read, dmem_write  out  1  data memory strobes
- reg_write, pc_inc, pc_load  out  1  one-cycle pulses
- busy  out  1  state is not IDLE or HALT
- halted  out  1  state is HALT
- instr_count  out  8  retired-instruction counter

Function
REQ-003 The state machine SHALL have the states IDLE, FETCH, DECODE, EXEC, MEM, WB, BRCHK and HALT.
REQ-004 The state machine SHALL make these transitions:
- IDLE→FETCH when start=1.
- FETCH holds imem_req=1 and waits until imem_ready=1, then latches instr and moves to DECODE.
- DECODE→EXEC.
REQ-005 Opcode decode in DECODE SHALL be:
- 000 R-type: ALUsrc=0, ALUcontrol=funct.
- 001 lw and 010 sw: ALUsrc=1, ALUcontrol=0.
- 100 addi: ALUsrc=1, ALUcontrol=0.
- 111 halt.
- 011 per REQ-017.
- All other opcodes are NOP.
REQ-006 opcode, ALUsrc and ALUcontrol SHALL be registered in DECODE and held stable until the next DECODE.
REQ-007 On every entry to EXEC, ex_stage SHALL invert exactly once. Only edges matter, not level.
REQ-008 EXEC SHALL last exactly one cycle, then go to:
- MEM for lw/sw.
- WB for R-type/addi.
- BRCHK for beq.
- FETCH for NOP.
- HALT for halt.
REQ-009 In MEM, dmem_read (lw) or dmem_write (sw) SHALL be held high until dmem_ready=1.
- lw then moves to WB.
- sw then moves to FETCH.
REQ-010 WB SHALL assert reg_write for exactly one cycle, then move to FETCH.
REQ-011 pc_inc SHALL pulse in the final cycle of every non-halt, non-taken-branch instruction. This is the same cycle in which instr_count increments (8-bit, wraps 255→0).
REQ-012 Minimum latency with ready inputs high SHALL be:
- 4 cycles for R/addi.
- 5 cycles for lw.
- 4 cycles for sw.
- 3 cycles for NOP.
REQ-013 HALT SHALL be absorbing and ignore start; only reset exits it. halt SHALL NOT increment instr_count.
REQ-014 start asserted while busy=1 SHALL be ignored.
REQ-015 If imem_ready and dmem_ready are both high in FETCH, only imem_ready SHALL be honoured; if both are high in MEM, only dmem_ready SHALL be honoured.

Reset
REQ-016 On reset=1, independent of clk:
- state=IDLE.
- Outputs opcode, ALUcontrol, ALUsrc, ex_stage, all strobes/pulses, busy, halted and instr_count are all 0.
- This applies equally when reset arrives mid-MEM; dmem strobes drop immediately and no pulse is emitted on release.

Configuration
REQ-017 The macro BRANCH_EN SHALL control opcode 011:
- Defined: 011 is beq. DECODE sets ALUsrc=0, ALUcontrol=1. BRCHK lasts one cycle and samples zero: zero=1 pulses pc_load (not pc_inc); zero=0 pulses pc_inc. Both cases increment instr_count and go to FETCH.
- Undefined: state BRCHK is absent and 011 is decoded as NOP.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset then start, instr=16'h0001 (sub), imem_ready=1 → ex_stage toggles once in cycle 3; reg_write and pc_inc pulse in cycle 4; instr_count=1.
- lw (16'h2000) with dmem_ready low for 3 cycles → dmem_read high 4 cycles, reg_write 1 cycle after; total 8 cycles.
- BRANCH_EN defined, beq (16'h6000) with zero=1 → pc_load=1 and pc_inc=0 in BRCHK; with zero=0 → pc_inc=1.
- 256 NOPs (16'hA000) → instr_count wraps to 0; pc_inc pulses 256 times.
- halt (16'hE000) then start=1 → halted=1, busy=0, instr_count unchanged; reset asserted → halted=0.
- Reset asserted mid-MEM of sw → dmem_write=0 within the same cycle; after release state is IDLE and no pc_inc occurs.
